pwm_breath_ctrl: RTL and testbench

Self-contained PWM "breathing" controller for the LED path.
- Owns the PWM period counter and sequences the duty cycle through ramp-up, hold-high, ramp-down and hold-low phases.
- Ramp and hold settings come from a valid/ready config port.
- Duty changes only at period boundaries, so the LED output never glitches mid-period.

---
 rtl/pwm_breath_ctrl.sv | 131 +++++++++++++
 tb/tb_pwm_breath_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pwm_breath_ctrl.sv
// PWM breathing controller: ramp-up / hold-high / ramp-down / hold-low duty sequencer.
// Define PWM_BREATH_GAMMA_EN to drive led from a squared (gamma) duty.
module pwm_breath_ctrl #(
    parameter int CNT_W  = 8,
    parameter int STEP_W = 4,
    parameter int HOLD_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [STEP_W-1:0] cfg_step,
    input  logic [HOLD_W-1:0] cfg_hold,
    input  logic [CNT_W-1:0]  cfg_max,
    output logic              led,
    output logic [CNT_W-1:0]  duty,
    output logic              period_end,
    output logic [2:0]        phase
);

    localparam int SW = ((CNT_W > STEP_W) ? CNT_W : STEP_W) + 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RAMP_UP   = 3'd1,
        HOLD_HI   = 3'd2,
        RAMP_DOWN = 3'd3,
        HOLD_LO   = 3'd4
    } phase_e;

    phase_e             phase_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   duty_q;
    logic [HOLD_W-1:0]  hold_cnt_q;
    logic [STEP_W-1:0]  step_q;
    logic [HOLD_W-1:0]  hold_q;
    logic [CNT_W-1:0]   max_q;

    logic [SW-1:0]      step_w;
    logic [SW-1:0]      duty_w;
    logic [SW-1:0]      max_w;
    logic [SW-1:0]      sum_w;
    logic [CNT_W-1:0]   up_d;
    logic [CNT_W-1:0]   dn_d;
    logic [CNT_W-1:0]   lvl;
    logic               last;
    logic               run;

    // Wide arithmetic so neither the ramp-up sum nor the ramp-down difference wraps.
    always_comb begin
        step_w = (step_q == '0) ? SW'(1) : SW'(step_q);
        duty_w = SW'(duty_q);
        max_w  = SW'(max_q);
        sum_w  = duty_w + step_w;
        up_d   = (sum_w > max_w) ? max_q : CNT_W'(sum_w);
        dn_d   = (duty_w > step_w) ? CNT_W'(duty_w - step_w) : '0;
    end

`ifdef PWM_BREATH_GAMMA_EN
    logic [2*CNT_W-1:0] sq;
    always_comb begin
        sq  = (2*CNT_W)'(duty_q) * (2*CNT_W)'(duty_q);
        lvl = CNT_W'(sq >> CNT_W);
    end
`else
    assign lvl = duty_q;
`endif

    assign run        = (phase_q != IDLE);
    assign last       = &cnt_q;
    assign period_end = run & last;
    assign led        = run & (cnt_q < lvl);
    assign duty       = duty_q;
    assign phase      = phase_q;
    assign cfg_ready  = !run;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q    <= IDLE;
            cnt_q      <= '0;
            duty_q     <= '0;
            hold_cnt_q <= '0;
            step_q     <= STEP_W'(1);
            hold_q     <= '0;
            max_q      <= '1;
        end else begin
            if (cfg_valid && !run) begin
                step_q <= cfg_step;
                hold_q <= cfg_hold;
                max_q  <= cfg_max;
            end
            if (!en || !run) begin
                cnt_q      <= '0;
                duty_q     <= '0;
                hold_cnt_q <= '0;
                phase_q    <= (en && !run) ? RAMP_UP : IDLE;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
                if (last) begin
                    unique case (phase_q)
                        RAMP_UP: begin
                            duty_q <= up_d;
                            if (up_d == max_q) begin
                                phase_q    <= HOLD_HI;
                                hold_cnt_q <= '0;
                            end
                        end
                        HOLD_HI: begin
                            if (hold_cnt_q == hold_q) phase_q <= RAMP_DOWN;
                            else hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
                        end
                        RAMP_DOWN: begin
                            duty_q <= dn_d;
                            if (dn_d == '0) begin
                                phase_q    <= HOLD_LO;
                                hold_cnt_q <= '0;
                            end
                        end
                        HOLD_LO: begin
                            if (hold_cnt_q == hold_q) phase_q <= RAMP_UP;
                            else hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
                        end
                        default: phase_q <= IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_breath_ctrl.sv
// Directed bench for pwm_breath_ctrl at CNT_W=4: per-period duty/phase table plus
// hand sequences for reset, ignored config, abort and restart.
module tb_pwm_breath_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       cfg_valid = 1'b0;
    logic       cfg_ready;
    logic [3:0] cfg_step = '0;
    logic [7:0] cfg_hold = '0;
    logic [3:0] cfg_max = '0;
    logic       led;
    logic [3:0] duty;
    logic       period_end;
    logic [2:0] phase;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pwm_breath_ctrl #(.CNT_W(4), .STEP_W(4), .HOLD_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_step(cfg_step), .cfg_hold(cfg_hold), .cfg_max(cfg_max),
        .led(led), .duty(duty), .period_end(period_end), .phase(phase)
    );

    typedef struct packed {
        logic       start;
        logic [3:0] step;
        logic [7:0] hold;
        logic [3:0] max;
        logic [3:0] exp_duty;
        logic [2:0] exp_ph;
    } vec_t;

    vec_t vecs[$];

    int s1d[12] = '{0, 4, 8, 12, 12, 12, 8, 4, 0, 0, 0, 4};
    int s1p[12] = '{1, 1, 1, 2, 2, 3, 3, 3, 4, 4, 1, 1};
    int s2d[12] = '{0, 5, 10, 12, 12, 7, 2, 0, 0, 5, 0, 0};
    int s2p[12] = '{1, 1, 1, 2, 3, 3, 3, 4, 1, 1, 0, 0};
    int s3d[12] = '{0, 1, 2, 3, 3, 2, 1, 0, 0, 1, 0, 0};
    int s3p[12] = '{1, 1, 1, 2, 3, 3, 3, 4, 1, 1, 0, 0};
    int s4d[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    int s4p[12] = '{1, 2, 3, 4, 1, 2, 3, 4, 1, 2, 0, 0};
    int s5d[12] = '{0, 15, 15, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    int s5p[12] = '{1, 2, 3, 4, 1, 0, 0, 0, 0, 0, 0, 0};

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int led_cnt(input int d);
`ifdef PWM_BREATH_GAMMA_EN
        return (d * d) >> 4;
`else
        return d;
`endif
    endfunction

    task automatic load(input int step, input int hold, input int max,
                        input int n, input int d[12], input int p[12]);
        vec_t v;
        for (int i = 0; i < n; i++) begin
            v.start    = (i == 0);
            v.step     = 4'(step);
            v.hold     = 8'(hold);
            v.max      = 4'(max);
            v.exp_duty = 4'(d[i]);
            v.exp_ph   = 3'(p[i]);
            vecs.push_back(v);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en = 1'b0;
        cfg_valid = 1'b0;
        #3;
        rst_n = 1'b1;
    endtask

    task automatic start_run(input int step, input int hold, input int max);
        do_reset();
        cfg_step = 4'(step);
        cfg_hold = 8'(hold);
        cfg_max = 4'(max);
        cfg_valid = 1'b1;
        en = 1'b1;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic run_period(input int d);
        int n = 0;
        int bad = 0;
        for (int c = 0; c < 16; c++) begin
            if (led) n++;
            if (period_end !== (c == 15)) bad++;
            tick();
        end
        chk("led_high_clocks", n, led_cnt(d));
        chk("period_end_pattern", bad, 0);
    endtask

    initial begin
        load(4, 1, 12, 12, s1d, s1p);
        load(5, 0, 12, 10, s2d, s2p);
        load(0, 0, 3, 10, s3d, s3p);
        load(2, 0, 0, 10, s4d, s4p);
        load(15, 0, 15, 5, s5d, s5p);

        #2;
        chk("rst_cfg_ready", int'(cfg_ready), 1);
        chk("rst_phase", int'(phase), 0);
        chk("rst_duty", int'(duty), 0);
        chk("rst_led", int'(led), 0);
        chk("rst_period_end", int'(period_end), 0);
        do_reset();

        foreach (vecs[i]) begin
            if (vecs[i].start)
                start_run(int'(vecs[i].step), int'(vecs[i].hold), int'(vecs[i].max));
            chk($sformatf("tbl%0d_duty", i), int'(duty), int'(vecs[i].exp_duty));
            chk($sformatf("tbl%0d_phase", i), int'(phase), int'(vecs[i].exp_ph));
            run_period(int'(vecs[i].exp_duty));
        end

        // Asynchronous reset in RAMP_DOWN, then restart on default shadow config.
        start_run(4, 0, 8);
        repeat (48) tick();
        chk("pre_rst_phase", int'(phase), 3);
        chk("pre_rst_duty", int'(duty), 8);
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        chk("async_rst_led", int'(led), 0);
        chk("async_rst_duty", int'(duty), 0);
        chk("async_rst_phase", int'(phase), 0);
        chk("async_rst_cfg_ready", int'(cfg_ready), 1);
        chk("async_rst_period_end", int'(period_end), 0);
        rst_n = 1'b1;
        tick();
        chk("restart_phase", int'(phase), 1);
        chk("restart_duty0", int'(duty), 0);
        repeat (16) tick();
        chk("default_step_duty1", int'(duty), 1);
        repeat (16) tick();
        chk("default_step_duty2", int'(duty), 2);

        // Config offered mid-ramp must be refused and ignored.
        start_run(4, 0, 12);
        repeat (3) tick();
        cfg_valid = 1'b1;
        cfg_step = 4'd1;
        cfg_max = 4'd3;
        cfg_hold = 8'd5;
        #1;
        chk("busy_cfg_ready", int'(cfg_ready), 0);
        repeat (13) tick();
        chk("ignored_cfg_duty4", int'(duty), 4);
        repeat (16) tick();
        chk("ignored_cfg_duty8", int'(duty), 8);
        repeat (16) tick();
        chk("ignored_cfg_duty12", int'(duty), 12);
        chk("ignored_cfg_phase", int'(phase), 2);
        cfg_valid = 1'b0;

        // Abort mid-period with en low.
        repeat (7) tick();
        en = 1'b0;
        tick();
        chk("abort_phase", int'(phase), 0);
        chk("abort_duty", int'(duty), 0);
        chk("abort_led", int'(led), 0);
        chk("abort_cfg_ready", int'(cfg_ready), 1);
        repeat (3) tick();
        chk("idle_period_end", int'(period_end), 0);
        chk("idle_phase", int'(phase), 0);
        en = 1'b1;
        tick();
        begin
            int c = 0;
            while (!period_end && c < 40) begin
                tick();
                c++;
            end
            chk("restart_first_period_len", c, 15);
        end
        tick();
        chk("restart_kept_cfg_duty", int'(duty), 4);
        en = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
